// File: rtl/writeback_pc_update.sv
// writeback_pc_update: SEQ writeback stage; commits register file, PC, status and retired count.
// Optional feature: define WB_BYPASS_EN to forward this cycle's committing write data onto the read ports.
// Ports:
//   clk_i, rst_ni     clock and synchronous active-low reset
//   icode_i, cnd_i    current opcode and execute condition
//   instr_valid_i     fetch decoded a legal opcode
//   imem_error_i      fetch address error
//   mem_error_i       data-memory error
//   dstE_i, valE_i    E write port (F = none)
//   dstM_i, valM_i    M write port (F = none); wins over E on the same register
//   valC_i, valP_i    jump/call target and fall-through PC
//   srcA_i, srcB_i    read addresses; valA_o/valB_o are the combinational read data
//   pc_o, stat_o      current PC and status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   retired_o         committed-instruction count
module writeback_pc_update #(
  parameter int NREGS = 15,
  parameter logic [63:0] PC_RST = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        mem_error_i,
  input  logic [3:0]  dstE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valM_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valP_i,
  input  logic [3:0]  srcA_i,
  input  logic [3:0]  srcB_i,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o,
  output logic [63:0] pc_o,
  output logic [2:0]  stat_o,
  output logic [63:0] retired_o
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];
  logic [63:0] pc_q, pc_d, retired_q, retired_d, base_a, base_b;
  logic [2:0]  stat_q, stat_d, new_stat;
  logic        commit, wr_ok, we_e, we_m;
  always_comb begin
    new_stat = (imem_error_i || mem_error_i) ? S_ADR :
               !instr_valid_i ? S_INS :
               (icode_i == 4'h0) ? S_HLT : S_AOK;
    commit = stat_q == S_AOK;
    // halt still commits its writes; ADR/INS commit nothing but the status
    wr_ok = commit && (new_stat == S_AOK || new_stat == S_HLT);
    // cmovXX with a false condition drops only the E write
    we_e = wr_ok && dstE_i != RNONE && int'(dstE_i) < NREGS && !(icode_i == 4'h2 && !cnd_i);
    we_m = wr_ok && dstM_i != RNONE && int'(dstM_i) < NREGS;
    for (int r = 0; r < NREGS; r++)
      regs_d[r] = (we_m && dstM_i == 4'(r)) ? valM_i :
                  (we_e && dstE_i == 4'(r)) ? valE_i : regs_q[r];
    pc_d = !(commit && new_stat == S_AOK) ? pc_q :
           (icode_i == 4'h8 || (icode_i == 4'h7 && cnd_i)) ? valC_i :
           (icode_i == 4'h9) ? valM_i : valP_i;
    stat_d = commit ? new_stat : stat_q;
    retired_d = wr_ok ? retired_q + 64'd1 : retired_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      pc_q <= PC_RST;
      stat_q <= S_AOK;
      retired_q <= '0;
    end else begin
      regs_q <= regs_d;
      pc_q <= pc_d;
      stat_q <= stat_d;
      retired_q <= retired_d;
    end
  end
  assign base_a = (srcA_i != RNONE && int'(srcA_i) < NREGS) ? regs_q[srcA_i] : '0;
  assign base_b = (srcB_i != RNONE && int'(srcB_i) < NREGS) ? regs_q[srcB_i] : '0;
`ifdef WB_BYPASS_EN
  assign valA_o = (we_m && srcA_i == dstM_i) ? valM_i : (we_e && srcA_i == dstE_i) ? valE_i : base_a;
  assign valB_o = (we_m && srcB_i == dstM_i) ? valM_i : (we_e && srcB_i == dstE_i) ? valE_i : base_b;
`else
  assign valA_o = base_a;
  assign valB_o = base_b;
`endif
  assign pc_o = pc_q;
  assign stat_o = stat_q;
  assign retired_o = retired_q;
endmodule

// File: tb/tb_writeback_pc_update.sv
// tb_writeback_pc_update: directed scoreboard bench for writeback_pc_update.
module tb_writeback_pc_update;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  icode = 4'h1, dstE = 4'hF, dstM = 4'hF, srcA = 4'hF, srcB = 4'hF;
  logic        cnd = 1'b0, ivalid = 1'b1, imerr = 1'b0, merr = 1'b0;
  logic [63:0] valE = '0, valM = '0, valC = '0, valP = '0;
  logic [63:0] valA, valB, pc, retired;
  logic [2:0]  stat;
  int checks = 0, failures = 0;
  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [63:0] ret;
    logic [3:0]  r;
    logic [63:0] rv;
  } exp_t;
  exp_t sb[$];
  writeback_pc_update dut (
    .clk_i(clk), .rst_ni(rst_n), .icode_i(icode), .cnd_i(cnd), .instr_valid_i(ivalid),
    .imem_error_i(imerr), .mem_error_i(merr), .dstE_i(dstE), .dstM_i(dstM),
    .valE_i(valE), .valM_i(valM), .valC_i(valC), .valP_i(valP),
    .srcA_i(srcA), .srcB_i(srcB), .valA_o(valA), .valB_o(valB),
    .pc_o(pc), .stat_o(stat), .retired_o(retired)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] ic, input logic c, input logic v,
                       input logic ie, input logic me, input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm, input logic [63:0] vc,
                       input logic [63:0] vp);
    rst_n = r; icode = ic; cnd = c; ivalid = v; imerr = ie; merr = me;
    dstE = de; dstM = dm; valE = ve; valM = vm; valC = vc; valP = vp;
  endtask
  task automatic fin(input string tag, input logic [63:0] epc, input logic [2:0] est,
                     input logic [63:0] eret, input logic [3:0] er, input logic [63:0] erv);
    exp_t e;
    sb.push_back('{tag, epc, est, eret, er, erv});
    @(posedge clk);
    #1;
    rst_n = 1'b1; dstE = 4'hF; dstM = 4'hF; imerr = 1'b0; merr = 1'b0; ivalid = 1'b1;
    srcA = er; srcB = er;
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_pc"}, pc, e.pc);
      chk({e.tag, "_stat"}, {61'd0, stat}, {61'd0, e.stat});
      chk({e.tag, "_retired"}, retired, e.ret);
      chk({e.tag, "_valA"}, valA, e.rv);
      chk({e.tag, "_valB"}, valB, e.rv);
    end
  endtask
  initial begin
    #2;
    drive(0, 4'h3, 0, 1, 0, 0, 4'h3, 4'hF, 64'hFF, 0, 0, 64'h5);
    fin("reset", 0, 1, 0, 4'h3, 0);
    drive(1, 4'h3, 0, 1, 0, 0, 4'h2, 4'hF, 64'hA5A5A5A5A5A5A5A5, 0, 0, 64'h10);
    fin("irmovq", 64'h10, 1, 1, 4'h2, 64'hA5A5A5A5A5A5A5A5);
    drive(1, 4'hB, 0, 1, 0, 0, 4'h4, 4'h4, 64'h8, 64'hDEADBEEF, 0, 64'h12);
    fin("popq_rsp", 64'h12, 1, 2, 4'h4, 64'hDEADBEEF);
    drive(1, 4'h8, 0, 1, 0, 0, 4'h3, 4'hF, 64'h77, 0, 64'h100, 64'h1A);
    fin("call", 64'h100, 1, 3, 4'h3, 64'h77);
    drive(1, 4'h9, 0, 1, 0, 0, 4'hF, 4'hF, 0, 64'h20, 64'h300, 64'h101);
    fin("ret", 64'h20, 1, 4, 4'h4, 64'hDEADBEEF);
    drive(1, 4'h2, 0, 1, 0, 0, 4'h5, 4'hF, 64'h55, 0, 0, 64'h22);
    fin("cmov_nt", 64'h22, 1, 5, 4'h5, 0);
    drive(1, 4'h2, 1, 1, 0, 0, 4'h5, 4'hF, 64'h55, 0, 0, 64'h24);
    fin("cmov_t", 64'h24, 1, 6, 4'h5, 64'h55);
    drive(1, 4'h7, 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 64'h40, 64'h30);
    fin("jxx_nt", 64'h30, 1, 7, 4'h2, 64'hA5A5A5A5A5A5A5A5);
    drive(1, 4'h7, 1, 1, 0, 0, 4'hF, 4'hF, 0, 0, 64'h40, 64'h32);
    fin("jxx_t", 64'h40, 1, 8, 4'h2, 64'hA5A5A5A5A5A5A5A5);
    drive(1, 4'h6, 0, 1, 0, 0, 4'hF, 4'hF, 64'h99, 64'h98, 0, 64'h42);
    fin("rnone", 64'h42, 1, 9, 4'hF, 0);
    drive(1, 4'h5, 0, 1, 0, 1, 4'h1, 4'hF, 64'h11, 0, 0, 64'h50);
    fin("mem_err", 64'h42, 3, 9, 4'h1, 0);
    drive(1, 4'h3, 0, 1, 0, 0, 4'h1, 4'hF, 64'h22, 0, 0, 64'h60);
    fin("frozen_adr", 64'h42, 3, 9, 4'h1, 0);
    drive(0, 4'h3, 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    fin("reset_adr", 0, 1, 0, 4'h2, 0);
    drive(1, 4'h3, 0, 0, 1, 0, 4'h2, 4'hF, 64'h5, 0, 0, 64'h8);
    fin("imem_err_prio", 0, 3, 0, 4'h2, 0);
    drive(0, 4'h3, 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    fin("reset2", 0, 1, 0, 4'h2, 0);
    drive(1, 4'h0, 0, 0, 0, 0, 4'h2, 4'hF, 64'h5, 0, 0, 64'h8);
    fin("ins", 0, 4, 0, 4'h2, 0);
    drive(1, 4'h3, 0, 1, 0, 0, 4'h2, 4'hF, 64'h5, 0, 0, 64'h8);
    fin("frozen_ins", 0, 4, 0, 4'h2, 0);
    drive(0, 4'h3, 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    fin("reset3", 0, 1, 0, 4'h6, 0);
    drive(1, 4'h3, 0, 1, 0, 0, 4'h6, 4'hF, 64'h66, 0, 0, 64'h8);
    srcA = 4'h6;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_valA", valA, 64'h66);
`else
    chk("bypass_valA", valA, 64'h0);
`endif
    fin("irmovq6", 64'h8, 1, 1, 4'h6, 64'h66);
    drive(1, 4'h0, 0, 1, 0, 0, 4'h7, 4'hF, 64'h70, 0, 64'h500, 64'h9);
    fin("halt", 64'h8, 2, 2, 4'h7, 64'h70);
    drive(1, 4'h3, 0, 1, 0, 0, 4'h6, 4'hF, 64'h1, 0, 0, 64'h20);
    fin("frozen_hlt", 64'h8, 2, 2, 4'h6, 64'h66);
    drive(0, 4'h3, 0, 1, 0, 0, 4'h6, 4'hF, 64'h1, 0, 0, 64'h20);
    fin("reset_hlt", 0, 1, 0, 4'h6, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
